multicycle_ctrl_hs: RTL and testbench
=====================================

# multicycle_ctrl_hs

Parametrised successor to the team's multicycle CPU control unit. Sequences each instruction through IF/ID/EXE/MEM/WB and drives datapath strobes. Adds a request/acknowledge handshake to instruction and data memory with a bounded wait timeout, a sticky halt/error state, and an instruction-retired counter. Sits between the datapath (opcode, Zero) and the memory interfaces.

## Interface
- `WAIT_MAX`, default 15: max cycles to wait for an ack in IF or MEM before bus error; 0 disables the timeout.
- `CNT_W`, default 32: width of the retired-instruction counter.
- `CLK` in 1: clock, rising edge.
- `RST` in 1: reset, synchronous, active-high.
- `Opcode` in 6: current instruction opcode from IR.
- `Zero` in 1: ALU zero flag.
- `imem_ack` in 1: instruction memory data valid.
- `dmem_ack` in 1: data memory access complete.
- `imem_req` out 1: instruction fetch request.
- `dmem_req` out 1: data memory request.
- `IRWre` out 1: IR load strobe.
- `PCWre`, `RegWre`, `ALUSrcB`, `ALUM2Reg`, `DataMemRW`, `WrRegData` out 1 each: datapath strobes.
- `ALUOp` out 3, `ExtSel` out 2, `PCSrc` out 2, `RegOut` out 2: datapath selects.
- `state` out 3: current state.
- `halted` out 1: in HALT.
- `bus_err` out 1: sticky, set by timeout.
- `illegal` out 1: sticky, set by undefined opcode (macro only).
- `retired` out CNT_W: instructions completed.

## Operation
- Opcodes: add 000000, sub 000001, addi 000010, or 010000, and 010001, ori 010010, sll 011000, move 100000, slt 100111, sw 110000, lw 110001, beq 110100, j 111000, jr 111001, jal 111010, halt 111111.
- ALUOp: add 000, sub 001, sll 010, or 011, and 100, slt 101. move uses add.
- ExtSel: zero 00 (ori), sign 01 (addi/lw/sw/beq), shamt 10 (sll).
- PCSrc: PC+4 00, branch 01, jr 10, jump 11.
- RegOut: $31 00, rt 01 (addi/ori/lw), rd 10.
- Outputs are combinational from state/Opcode/Zero/acks. Any strobe not listed for a state is 0.
- IF: `imem_req`=1. On `imem_ack`: `IRWre`=1, go to ID.
- ID:
  - j: `PCWre`=1, `PCSrc`=11, go to IF.
  - jr: `PCWre`=1, `PCSrc`=10, go to IF.
  - jal: `PCWre`=1, `PCSrc`=11, `RegWre`=1, `RegOut`=00, `WrRegData`=0, go to IF.
  - halt: go to HALT.
  - Otherwise go to EXE.
- EXE: ALUOp/ExtSel/`ALUSrcB` (1 for immediates, lw, sw) held through later states.
  - beq: ALUOp sub, `PCWre`=1, `PCSrc`=Zero?01:00, go to IF.
  - lw/sw: go to MEM.
  - All others: go to WB.
- MEM: `dmem_req`=1, `DataMemRW`=1 for sw. On `dmem_ack`: sw gives `PCWre`=1 and goes to IF; lw goes to WB.
- WB: `RegWre`=1, `WrRegData`=1, `ALUM2Reg`=1 for lw, `PCWre`=1, go to IF.
- HALT: absorbing until `RST`. `halted`=1, all strobes and requests 0.
- `retired` increments by 1 on every cycle with `PCWre`=1. It wraps modulo 2^CNT_W.

## Timing
- Reset cycle: state←IF; `retired`, `bus_err`, `illegal`, wait counter ← 0. While `RST` is high, every output is forced to 0, including the requests.
- First `imem_req` appears in the cycle after `RST` falls.
- Latency with zero-wait acks (ack in the same cycle as req):
  - j/jr/jal: 2 cycles.
  - beq: 3 cycles.
  - sw and ALU ops: 4 cycles.
  - lw: 5 cycles.
- Each ack-cycle delay adds 1 cycle.
- Requests stay high until ack. An ack while req is low is ignored.
- Wait counter clears on entering IF or MEM and increments each cycle without ack.
  - If WAIT_MAX>0 and the counter reaches WAIT_MAX with no ack, go to HALT next cycle and set `bus_err`.
  - An ack in the same cycle the counter reaches WAIT_MAX wins; there is no error.
- `RST` mid-instruction or in HALT aborts immediately. No strobe is issued that cycle.

## Configuration
- `MCU_TRAP_EN` defined: an undefined opcode in ID goes to HALT and sets `illegal`. It is not counted as retired.
- `MCU_TRAP_EN` undefined: an undefined opcode is a NOP. ID asserts `PCWre`=1, `PCSrc`=00, returns to IF, and counts as retired. `illegal` is tied 0.

## Structure
- Package `mcu_pkg` holds: state encodings (IF 000, ID 001, EXE 010, MEM 011, WB 100, HALT 111), opcode constants, and the ALUOp/ExtSel/PCSrc/RegOut codes.
- Sub-module `mcu_wait_timer` holds the wait counter and timeout compare: clear, tick, ack in; expired out.

## Test plan
- addi with zero-wait acks: states IF→ID→EXE→WB→IF over 4 cycles. WB shows `RegWre`=1, `RegOut`=01, `ExtSel`=01. `retired` goes 0→1.
- lw with `dmem_ack` delayed 3 cycles: MEM lasts 4 cycles with `dmem_req` high throughout. WB shows `ALUM2Reg`=1. Total 8 cycles.
- beq with Zero=1, then with Zero=0: EXE shows `PCSrc`=01, then 00. `PCWre`=1 both times.
- `imem_ack` never asserted, WAIT_MAX=15: HALT after IF+15 cycles. `bus_err`=1, `halted`=1, `imem_req`=0. Only `RST` recovers.
- Opcode 101010: with `MCU_TRAP_EN`, goes to HALT with `illegal`=1 and `retired` unchanged. Without it, 2-cycle NOP and `retired`+1.
- `RST` asserted mid-MEM of sw: next cycle state=IF, `DataMemRW`=0, `retired`=0, sticky flags cleared.

Source files
------------

// File: rtl/mcu_pkg.sv
// Shared encodings for the handshaked multicycle control unit: states, opcodes,
// datapath select codes and the EXE-stage decode helpers.
package mcu_pkg;

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EXE  = 3'b010,
    S_MEM  = 3'b011,
    S_WB   = 3'b100,
    S_HALT = 3'b111
  } state_t;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_ORI  = 6'b010010;
  localparam logic [5:0] OP_SLL  = 6'b011000;
  localparam logic [5:0] OP_MOVE = 6'b100000;
  localparam logic [5:0] OP_SLT  = 6'b100111;
  localparam logic [5:0] OP_SW   = 6'b110000;
  localparam logic [5:0] OP_LW   = 6'b110001;
  localparam logic [5:0] OP_BEQ  = 6'b110100;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_JR   = 6'b111001;
  localparam logic [5:0] OP_JAL  = 6'b111010;
  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLL = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] EXT_ZERO  = 2'b00;
  localparam logic [1:0] EXT_SIGN  = 2'b01;
  localparam logic [1:0] EXT_SHAMT = 2'b10;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JR     = 2'b10;
  localparam logic [1:0] PC_JUMP   = 2'b11;

  localparam logic [1:0] RO_R31 = 2'b00;
  localparam logic [1:0] RO_RT  = 2'b01;
  localparam logic [1:0] RO_RD  = 2'b10;

  typedef struct packed {
    logic [2:0] aluop;
    logic [1:0] extsel;
    logic       alusrcb;
    logic       dest_rt;
  } exe_ctrl_t;

  function automatic logic is_legal_op(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_ADDI, OP_OR, OP_AND, OP_ORI, OP_SLL, OP_MOVE,
      OP_SLT, OP_SW, OP_LW, OP_BEQ, OP_J, OP_JR, OP_JAL, OP_HALT: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // ALU/extender settings that appear in EXE and stay valid through MEM and WB.
  function automatic exe_ctrl_t exe_decode(input logic [5:0] op);
    exe_ctrl_t c;
    c.aluop   = ALU_ADD;
    c.extsel  = EXT_ZERO;
    c.alusrcb = 1'b0;
    c.dest_rt = 1'b0;
    case (op)
      OP_SUB:  c.aluop = ALU_SUB;
      OP_ADDI: begin c.extsel = EXT_SIGN; c.alusrcb = 1'b1; c.dest_rt = 1'b1; end
      OP_OR:   c.aluop = ALU_OR;
      OP_AND:  c.aluop = ALU_AND;
      OP_ORI:  begin c.aluop = ALU_OR; c.alusrcb = 1'b1; c.dest_rt = 1'b1; end
      OP_SLL:  begin c.aluop = ALU_SLL; c.extsel = EXT_SHAMT; end
      OP_SLT:  c.aluop = ALU_SLT;
      OP_SW:   begin c.extsel = EXT_SIGN; c.alusrcb = 1'b1; end
      OP_LW:   begin c.extsel = EXT_SIGN; c.alusrcb = 1'b1; c.dest_rt = 1'b1; end
      OP_BEQ:  begin c.aluop = ALU_SUB; c.extsel = EXT_SIGN; end
      default: c.aluop = ALU_ADD;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mcu_wait_timer.sv
// Ack wait counter for the IF/MEM handshakes; flags expiry when WAIT_MAX
// cycles have elapsed without an ack. WAIT_MAX = 0 disables expiry.
module mcu_wait_timer #(
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  input  logic ack,
  output logic expired
);

  localparam int CW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] LIMIT = CW'(WAIT_MAX);
  localparam logic ENABLE = (WAIT_MAX > 0);

  logic [CW-1:0] cnt_r;

  // Count unacknowledged wait cycles, saturating at the limit.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_r <= {CW{1'b0}};
    end else if (tick && !ack && (cnt_r != LIMIT)) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // An ack arriving in the limit cycle takes priority over expiry.
  always_comb begin
    expired = ENABLE & tick & ~ack & (cnt_r == LIMIT);
  end

endmodule

// File: rtl/multicycle_ctrl_hs.sv
// Multicycle CPU control unit with req/ack memory handshakes, bus timeout,
// sticky halt/error flags and a retired-instruction counter.
// Define MCU_TRAP_EN to trap undefined opcodes into HALT (else they are NOPs).
module multicycle_ctrl_hs
  import mcu_pkg::*;
#(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [5:0]       Opcode,
  input  logic             Zero,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             IRWre,
  output logic             PCWre,
  output logic             RegWre,
  output logic             ALUSrcB,
  output logic             ALUM2Reg,
  output logic             DataMemRW,
  output logic             WrRegData,
  output logic [2:0]       ALUOp,
  output logic [1:0]       ExtSel,
  output logic [1:0]       PCSrc,
  output logic [1:0]       RegOut,
  output logic [2:0]       state,
  output logic             halted,
  output logic             bus_err,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  state_t           state_r, next_s;
  logic             expired_s, tick_s, clear_s, trap_s, wait_ack_s;
  logic             bus_err_r, illegal_r;
  logic [CNT_W-1:0] retired_r;
  exe_ctrl_t        exe_s;

  assign exe_s      = exe_decode(Opcode);
  assign tick_s     = (state_r == S_IF) || (state_r == S_MEM);
  assign wait_ack_s = (state_r == S_IF) ? imem_ack : dmem_ack;
  assign clear_s    = (next_s != state_r);

  mcu_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait (
    .clk     (CLK),
    .rst     (RST),
    .clear   (clear_s),
    .tick    (tick_s),
    .ack     (wait_ack_s),
    .expired (expired_s)
  );

`ifdef MCU_TRAP_EN
  assign trap_s = (state_r == S_ID) && !is_legal_op(Opcode);
`else
  assign trap_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= S_IF;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_s = state_r;
    case (state_r)
      S_IF: begin
        if (imem_ack)       next_s = S_ID;
        else if (expired_s) next_s = S_HALT;
        else                next_s = S_IF;
      end
      S_ID: begin
        case (Opcode)
          OP_J, OP_JR, OP_JAL: next_s = S_IF;
          OP_HALT:             next_s = S_HALT;
          default: begin
            if (is_legal_op(Opcode)) begin
              next_s = S_EXE;
            end else begin
`ifdef MCU_TRAP_EN
              next_s = S_HALT;
`else
              next_s = S_IF;
`endif
            end
          end
        endcase
      end
      S_EXE: begin
        if (Opcode == OP_BEQ)                         next_s = S_IF;
        else if ((Opcode == OP_LW) || (Opcode == OP_SW)) next_s = S_MEM;
        else                                          next_s = S_WB;
      end
      S_MEM: begin
        if (dmem_ack)       next_s = (Opcode == OP_SW) ? S_IF : S_WB;
        else if (expired_s) next_s = S_HALT;
        else                next_s = S_MEM;
      end
      S_WB:    next_s = S_IF;
      S_HALT:  next_s = S_HALT;
      default: next_s = S_IF;
    endcase
  end

  // Output decode; everything is held at zero while RST is asserted.
  always_comb begin
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    IRWre     = 1'b0;
    PCWre     = 1'b0;
    RegWre    = 1'b0;
    ALUSrcB   = 1'b0;
    ALUM2Reg  = 1'b0;
    DataMemRW = 1'b0;
    WrRegData = 1'b0;
    ALUOp     = ALU_ADD;
    ExtSel    = EXT_ZERO;
    PCSrc     = PC_SEQ;
    RegOut    = RO_R31;
    state     = 3'b000;
    halted    = 1'b0;
    bus_err   = 1'b0;
    illegal   = 1'b0;
    retired   = {CNT_W{1'b0}};
    if (RST) begin
      state = 3'b000;
    end else begin
      state   = state_r;
      halted  = (state_r == S_HALT);
      bus_err = bus_err_r;
      illegal = illegal_r;
      retired = retired_r;
      case (state_r)
        S_IF: begin
          imem_req = 1'b1;
          IRWre    = imem_ack;
        end
        S_ID: begin
          case (Opcode)
            OP_J:  begin PCWre = 1'b1; PCSrc = PC_JUMP; end
            OP_JR: begin PCWre = 1'b1; PCSrc = PC_JR; end
            OP_JAL: begin
              PCWre     = 1'b1;
              PCSrc     = PC_JUMP;
              RegWre    = 1'b1;
              RegOut    = RO_R31;
              WrRegData = 1'b0;
            end
            OP_HALT: PCWre = 1'b0;
            default: begin
`ifdef MCU_TRAP_EN
              PCWre = 1'b0;
`else
              if (!is_legal_op(Opcode)) begin
                PCWre = 1'b1;
                PCSrc = PC_SEQ;
              end else begin
                PCWre = 1'b0;
              end
`endif
            end
          endcase
        end
        S_EXE: begin
          ALUOp   = exe_s.aluop;
          ExtSel  = exe_s.extsel;
          ALUSrcB = exe_s.alusrcb;
          if (Opcode == OP_BEQ) begin
            PCWre = 1'b1;
            PCSrc = Zero ? PC_BRANCH : PC_SEQ;
          end else begin
            PCWre = 1'b0;
          end
        end
        S_MEM: begin
          ALUOp     = exe_s.aluop;
          ExtSel    = exe_s.extsel;
          ALUSrcB   = exe_s.alusrcb;
          dmem_req  = 1'b1;
          DataMemRW = (Opcode == OP_SW);
          PCWre     = dmem_ack && (Opcode == OP_SW);
        end
        S_WB: begin
          ALUOp     = exe_s.aluop;
          ExtSel    = exe_s.extsel;
          ALUSrcB   = exe_s.alusrcb;
          RegWre    = 1'b1;
          WrRegData = 1'b1;
          ALUM2Reg  = (Opcode == OP_LW);
          RegOut    = exe_s.dest_rt ? RO_RT : RO_RD;
          PCWre     = 1'b1;
        end
        S_HALT:  halted = 1'b1;
        default: halted = 1'b0;
      endcase
    end
  end

  // Retired counter and sticky error flags; PCWre marks instruction completion.
  always_ff @(posedge CLK) begin
    if (RST) begin
      retired_r <= {CNT_W{1'b0}};
      bus_err_r <= 1'b0;
      illegal_r <= 1'b0;
    end else begin
      retired_r <= PCWre ? (retired_r + CNT_W'(1)) : retired_r;
      bus_err_r <= bus_err_r | expired_s;
      illegal_r <= illegal_r | trap_s;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl_hs.sv
// Directed self-checking bench for multicycle_ctrl_hs with hand-computed
// expectations; honours MCU_TRAP_EN for the undefined-opcode case.
module tb_multicycle_ctrl_hs;
  import mcu_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [5:0]  Opcode = 6'b000000;
  logic        Zero = 1'b0;
  logic        imem_ack = 1'b0;
  logic        dmem_ack = 1'b0;
  logic        imem_req, dmem_req, IRWre, PCWre, RegWre, ALUSrcB, ALUM2Reg;
  logic        DataMemRW, WrRegData, halted, bus_err, illegal;
  logic [2:0]  ALUOp, state;
  logic [1:0]  ExtSel, PCSrc, RegOut;
  logic [31:0] retired;

  int checks = 0;
  int errors = 0;
  int exp_ret = 0;

  always #5 CLK = ~CLK;

  multicycle_ctrl_hs #(.WAIT_MAX(15), .CNT_W(32)) dut (
    .CLK(CLK), .RST(RST), .Opcode(Opcode), .Zero(Zero),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .imem_req(imem_req), .dmem_req(dmem_req), .IRWre(IRWre), .PCWre(PCWre),
    .RegWre(RegWre), .ALUSrcB(ALUSrcB), .ALUM2Reg(ALUM2Reg),
    .DataMemRW(DataMemRW), .WrRegData(WrRegData), .ALUOp(ALUOp),
    .ExtSel(ExtSel), .PCSrc(PCSrc), .RegOut(RegOut), .state(state),
    .halted(halted), .bus_err(bus_err), .illegal(illegal), .retired(retired)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Zero-wait fetch of op; returns settled in ID.
  task automatic fetch(input logic [5:0] op);
    Opcode   = op;
    imem_ack = 1'b1;
    #1;
    chk("if_state", state, 3'd0);
    chk("if_req", imem_req, 1'b1);
    chk("if_irwre", IRWre, 1'b1);
    tick();
    imem_ack = 1'b0;
    #1;
    chk("id_state", state, 3'd1);
  endtask

  initial begin
    // Reset
    RST = 1'b1;
    tick();
    tick();
    chk("rst_state", state, 3'd0);
    chk("rst_ireq", imem_req, 1'b0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_halted", halted, 1'b0);
    RST = 1'b0;
    #1;
    chk("post_rst_state", state, 3'd0);
    chk("post_rst_ireq", imem_req, 1'b1);

    // addi: IF ID EXE WB
    fetch(OP_ADDI);
    chk("addi_id_pcwre", PCWre, 1'b0);
    tick();
    chk("addi_exe_state", state, 3'd2);
    chk("addi_exe_srcb", ALUSrcB, 1'b1);
    chk("addi_exe_ext", ExtSel, 2'b01);
    tick();
    chk("addi_wb_state", state, 3'd4);
    chk("addi_wb_regwre", RegWre, 1'b1);
    chk("addi_wb_regout", RegOut, 2'b01);
    chk("addi_wb_ext", ExtSel, 2'b01);
    chk("addi_wb_pcwre", PCWre, 1'b1);
    chk("addi_wb_ret", retired, 32'd0);
    tick();
    exp_ret = 1;
    chk("addi_done_state", state, 3'd0);
    chk("addi_done_ret", retired, 32'(exp_ret));

    // lw with dmem_ack delayed 3 cycles
    fetch(OP_LW);
    tick();
    chk("lw_exe_state", state, 3'd2);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("lw_mem_wait_state", state, 3'd3);
      chk("lw_mem_wait_req", dmem_req, 1'b1);
      chk("lw_mem_wait_pcwre", PCWre, 1'b0);
      tick();
    end
    dmem_ack = 1'b1;
    #1;
    chk("lw_mem_ack_state", state, 3'd3);
    chk("lw_mem_ack_req", dmem_req, 1'b1);
    chk("lw_mem_rw", DataMemRW, 1'b0);
    tick();
    dmem_ack = 1'b0;
    #1;
    chk("lw_wb_state", state, 3'd4);
    chk("lw_wb_m2reg", ALUM2Reg, 1'b1);
    chk("lw_wb_regout", RegOut, 2'b01);
    tick();
    exp_ret = 2;
    chk("lw_done_state", state, 3'd0);
    chk("lw_done_ret", retired, 32'(exp_ret));

    // beq taken then not taken
    for (int z = 1; z >= 0; z--) begin
      fetch(OP_BEQ);
      Zero = z[0];
      tick();
      chk("beq_exe_state", state, 3'd2);
      chk("beq_aluop", ALUOp, 3'b001);
      chk("beq_pcwre", PCWre, 1'b1);
      chk("beq_pcsrc", PCSrc, (z == 1) ? 2'b01 : 2'b00);
      tick();
      exp_ret++;
      chk("beq_done_state", state, 3'd0);
      chk("beq_done_ret", retired, 32'(exp_ret));
    end
    Zero = 1'b0;

    // j and jal: 2 cycles each
    fetch(OP_J);
    chk("j_pcwre", PCWre, 1'b1);
    chk("j_pcsrc", PCSrc, 2'b11);
    tick();
    exp_ret++;
    chk("j_done_state", state, 3'd0);
    chk("j_done_ret", retired, 32'(exp_ret));
    fetch(OP_JAL);
    chk("jal_pcsrc", PCSrc, 2'b11);
    chk("jal_regwre", RegWre, 1'b1);
    chk("jal_regout", RegOut, 2'b00);
    chk("jal_wrdata", WrRegData, 1'b0);
    tick();
    exp_ret++;
    chk("jal_done_ret", retired, 32'(exp_ret));

    // sw with zero-wait ack
    fetch(OP_SW);
    tick();
    tick();
    dmem_ack = 1'b1;
    #1;
    chk("sw_mem_state", state, 3'd3);
    chk("sw_mem_rw", DataMemRW, 1'b1);
    chk("sw_mem_pcwre", PCWre, 1'b1);
    tick();
    dmem_ack = 1'b0;
    exp_ret++;
    #1;
    chk("sw_done_state", state, 3'd0);
    chk("sw_done_ret", retired, 32'(exp_ret));

    // imem_ack never comes: 16 IF cycles then HALT
    Opcode = OP_ADD;
    for (int i = 0; i < 16; i++) begin
      chk("to_if_state", state, 3'd0);
      chk("to_if_req", imem_req, 1'b1);
      tick();
    end
    chk("to_halt_state", state, 3'd7);
    chk("to_bus_err", bus_err, 1'b1);
    chk("to_halted", halted, 1'b1);
    chk("to_ireq", imem_req, 1'b0);
    chk("to_ret", retired, 32'(exp_ret));
    imem_ack = 1'b1;
    tick();
    tick();
    chk("halt_sticky_state", state, 3'd7);
    chk("halt_sticky_irwre", IRWre, 1'b0);
    imem_ack = 1'b0;

    // Reset out of HALT
    RST = 1'b1;
    #1;
    chk("halt_rst_buserr", bus_err, 1'b0);
    chk("halt_rst_halted", halted, 1'b0);
    tick();
    RST = 1'b0;
    exp_ret = 0;
    #1;
    chk("halt_rec_state", state, 3'd0);
    chk("halt_rec_buserr", bus_err, 1'b0);
    chk("halt_rec_ret", retired, 32'd0);

    // Ack in the limit cycle wins over timeout
    Opcode = OP_J;
    for (int i = 0; i < 15; i++) tick();
    imem_ack = 1'b1;
    #1;
    chk("edge_state", state, 3'd0);
    chk("edge_irwre", IRWre, 1'b1);
    tick();
    imem_ack = 1'b0;
    #1;
    chk("edge_id_state", state, 3'd1);
    chk("edge_buserr", bus_err, 1'b0);
    tick();
    exp_ret = 1;
    chk("edge_ret", retired, 32'(exp_ret));

    // RST during MEM of sw aborts with no strobe
    fetch(OP_SW);
    tick();
    tick();
    chk("swr_mem_state", state, 3'd3);
    chk("swr_mem_rw", DataMemRW, 1'b1);
    RST = 1'b1;
    dmem_ack = 1'b1;
    #1;
    chk("swr_rst_rw", DataMemRW, 1'b0);
    chk("swr_rst_req", dmem_req, 1'b0);
    chk("swr_rst_pcwre", PCWre, 1'b0);
    tick();
    RST = 1'b0;
    dmem_ack = 1'b0;
    exp_ret = 0;
    #1;
    chk("swr_state", state, 3'd0);
    chk("swr_rw", DataMemRW, 1'b0);
    chk("swr_ret", retired, 32'd0);
    chk("swr_buserr", bus_err, 1'b0);
    chk("swr_illegal", illegal, 1'b0);

    // Undefined opcode 101010
    fetch(6'b101010);
`ifdef MCU_TRAP_EN
    chk("ill_id_pcwre", PCWre, 1'b0);
    tick();
    chk("ill_state", state, 3'd7);
    chk("ill_flag", illegal, 1'b1);
    chk("ill_halted", halted, 1'b1);
    chk("ill_ret", retired, 32'(exp_ret));
`else
    chk("nop_pcwre", PCWre, 1'b1);
    chk("nop_pcsrc", PCSrc, 2'b00);
    tick();
    exp_ret++;
    chk("nop_state", state, 3'd0);
    chk("nop_illegal", illegal, 1'b0);
    chk("nop_ret", retired, 32'(exp_ret));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
